hilo_muldiv_ctrl: RTL and testbench
===================================

HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, regardless of clk).
REQ-003 SHALL have port start  in  1  EX-stage HI/LO-writing instruction valid; held high by the stalled pipeline.
REQ-004 SHALL have port op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (treated as no-op, never accepted).
REQ-005 SHALL have port src_a  in  32  rs operand (dividend / multiplicand / MT data).
REQ-006 SHALL have port src_b  in  32  rt operand (divisor / multiplier).
REQ-007 SHALL have port hilo_cur  in  64  current {HI,LO} from the HI/LO register, used for the MTHI/MTLO merge.
REQ-008 SHALL have port flush  in  1  exception/pipeline flush; cancels any operation in flight.
REQ-009 SHALL have port stall  out  1  pipeline stall request, combinational.
REQ-010 SHALL have port hilo_we  out  1  one-cycle write enable to the HI/LO register (writes both halves).
REQ-011 SHALL have port hilo_wdata  out  64  {HI,LO} value to write, registered.
REQ-012 SHALL have port div_zero  out  1  one-cycle pulse when DIV/DIVU completes with src_b==0.

Function
REQ-013 SHALL implement a state machine with states IDLE, MUL, DIV, DONE.
REQ-014 SHALL accept an operation only in IDLE when start=1, flush=0, and op is 0-5; start is ignored in every other state.
REQ-015 SHALL latch op, src_a, src_b (and hilo_cur for MT ops) on acceptance.
REQ-016 SHALL transition on acceptance: ops 0-1 -> MUL; ops 2-3 -> DIV; ops 4-5 -> DONE.
REQ-017 SHALL drive stall=1 in MUL and DIV.
REQ-018 SHALL drive stall=1 in IDLE during the cycle an operation is accepted.
REQ-019 SHALL drive stall=0 in DONE, so that the issuing instruction leaves EX in the same cycle that hilo_we fires.
REQ-020 In MUL, SHALL register the 64-bit product in one cycle and then go to DONE; MULT is signed, MULTU unsigned; hilo_wdata = {product[63:32], product[31:0]}.
REQ-021 In DIV, SHALL run a radix-2 restoring divider on operand magnitudes, one quotient bit per cycle, exactly 32 cycles in DIV, then go to DONE.
REQ-022 SHALL apply signed division fix-up for DIV only: quotient negated when operand signs differ; remainder takes the sign of the dividend. Result: HI=remainder, LO=quotient.
REQ-023 For DIV/DIVU with src_b==0, SHALL skip iteration (IDLE -> DONE directly) and drive hilo_we=0 and div_zero=1 in DONE.
REQ-024 For MTHI, SHALL set hilo_wdata = {src_a, hilo_cur[31:0]}; for MTLO, hilo_wdata = {hilo_cur[63:32], src_a}.
REQ-025 SHALL keep DONE for exactly one cycle, then go to IDLE; hilo_we = (state==DONE) & ~flush & ~divide-by-zero.
REQ-026 On flush=1 in MUL, DIV or DONE, SHALL go to IDLE next cycle with no hilo_we and no div_zero pulse; the DIV iteration counter is cleared.
REQ-027 DIV signed overflow (0x80000000 / 0xFFFFFFFF) SHALL produce LO=0x80000000, HI=0 (natural wrap of the magnitude algorithm).
REQ-028 Latency from the acceptance cycle T: MT ops write at T+1, MULT/MULTU at T+2, DIV/DIVU at T+33, divide-by-zero DONE at T+1.

Reset
REQ-029 On rst=0, SHALL force state IDLE, iteration counter 0, hilo_wdata 0, hilo_we 0, div_zero 0, stall 0.
REQ-030 On rst=1 release, SHALL ignore any start not sampled at a rising edge after release.
REQ-031 Reset asserted mid-DIV SHALL abort the operation with no write.

Verification
REQ-032 MULT src_a=0xFFFFFFFE (-2), src_b=3 -> stall high for 2 cycles; hilo_we at T+2 with wdata 0xFFFFFFFF_FFFFFFFA.
REQ-033 MULTU src_a=0xFFFFFFFF, src_b=2 -> wdata 0x00000001_FFFFFFFE at T+2.
REQ-034 DIV src_a=-7 (0xFFFFFFF9), src_b=2 -> 33 stall cycles; hilo_we at T+33 with HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-035 DIVU src_b=0 -> DONE at T+1, hilo_we=0, div_zero=1 for one cycle.
REQ-036 MTLO src_a=0x12345678 with hilo_cur=0xAAAAAAAA_BBBBBBBB -> wdata 0xAAAAAAAA_12345678 at T+1.
REQ-037 DIV started, flush at iteration 10 -> IDLE next cycle, no hilo_we; a new MULT accepted immediately after completes normally.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide/move controller: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO
// into a single 64-bit {HI,LO} write.
// Latency from the acceptance cycle T: MT ops write at T+1, MULT/MULTU at T+2,
// DIV/DIVU at T+33, and a divide-by-zero reaches DONE at T+1.
// Backpressure: stall is raised combinationally while an operation is accepted
// and while it is in flight, and drops in DONE so the issuing instruction leaves
// EX in the same cycle hilo_we fires.
//
// Ports:
//   clk, rst      - clock; asynchronous active-low reset
//   start, op     - EX-stage HI/LO instruction valid and opcode (0..5 valid, 6/7 ignored)
//   src_a, src_b  - rs / rt operands
//   hilo_cur      - current {HI,LO}, merged for MTHI/MTLO
//   flush         - cancels any operation in flight
//   stall         - pipeline stall request (combinational)
//   hilo_we       - one-cycle write enable for both halves of HI/LO
//   hilo_wdata    - registered {HI,LO} value to write
//   div_zero      - one-cycle pulse when DIV/DIVU completes with a zero divisor
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] hilo_cur,
  input  logic        flush,
  output logic        stall,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        div_zero
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_mul_sgn;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_dz;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_wdata;

  // ---------------------------------------------------------------------------
  // Issue decode
  // ---------------------------------------------------------------------------
  logic        w_accept;
  logic        w_op_mul;
  logic        w_op_div;
  logic        w_sgn_div;
  logic        w_dz_in;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;

  assign w_op_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign w_op_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_sgn_div = (op == OP_DIV);
  assign w_dz_in   = w_op_div && (src_b == 32'd0);
  assign w_accept  = (r_state == S_IDLE) && start && !flush && (op <= OP_MTLO);

  // The divider works on magnitudes; signs are re-applied on the last step.
  assign w_mag_a = (w_sgn_div && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign w_mag_b = (w_sgn_div && src_b[31]) ? (~src_b + 32'd1) : src_b;

  // ---------------------------------------------------------------------------
  // Multiplier: sign- or zero-extend to 64 bits, keep the low 64 product bits
  // (which equal the exact 32x32 result in both cases).
  // ---------------------------------------------------------------------------
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;

  assign w_ext_a = r_mul_sgn ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_ext_b = r_mul_sgn ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // ---------------------------------------------------------------------------
  // Restoring divider step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits. The partial remainder is always
  // below the divisor, so 32 bits hold it after the step; the 33rd bit only
  // matters for the compare.
  // ---------------------------------------------------------------------------
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_rem_fix;
  logic [31:0] w_quo_fix;

  assign w_shift   = {r_rem, r_quo[31]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_sub     = w_shift[31:0] - r_dvs;
  assign w_rem_nx  = w_ge ? w_sub : w_shift[31:0];
  assign w_quo_nx  = {r_quo[30:0], w_ge};
  assign w_rem_fix = r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;
  assign w_quo_fix = r_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    stall    = 1'b0;
    hilo_we  = 1'b0;
    div_zero = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall = 1'b1;
          if (w_op_mul)                  w_next = S_MUL;
          else if (w_op_div && !w_dz_in) w_next = S_DIV;
          else                           w_next = S_DONE;
        end
      end
      S_MUL: begin
        stall  = 1'b1;
        w_next = flush ? S_IDLE : S_DONE;
      end
      S_DIV: begin
        stall = 1'b1;
        if (flush)                w_next = S_IDLE;
        else if (r_cnt == 5'd31)  w_next = S_DONE;
      end
      S_DONE: begin
        w_next   = S_IDLE;
        hilo_we  = !flush && !r_dz;
        div_zero = !flush && r_dz;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_sgn <= 1'b0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_dz      <= 1'b0;
      r_cnt     <= 5'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_dvs     <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_wdata   <= 64'd0;
    end else begin
      if (w_accept) begin
        r_mul_sgn <= (op == OP_MULT);
        r_a       <= src_a;
        r_b       <= src_b;
        r_dz      <= w_dz_in;
        r_cnt     <= 5'd0;
        r_rem     <= 32'd0;
        r_quo     <= w_mag_a;
        r_dvs     <= w_mag_b;
        r_neg_q   <= w_sgn_div && (src_a[31] ^ src_b[31]);
        r_neg_r   <= w_sgn_div && src_a[31];
        // MT merges are resolved at issue against the HI/LO value of that cycle.
        if (op == OP_MTHI)      r_wdata <= {src_a, hilo_cur[31:0]};
        else if (op == OP_MTLO) r_wdata <= {hilo_cur[63:32], src_a};
      end

      case (r_state)
        S_MUL: r_wdata <= w_prod;
        S_DIV: begin
          if (flush) begin
            r_cnt <= 5'd0;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_wdata <= {w_rem_fix, w_quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign hilo_wdata = r_wdata;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: hand-computed vectors for each opcode,
// flush and reset cases, checked with immediate assertions.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_hilo_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [63:0] hilo_cur;
  logic        flush;
  logic        stall;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic        div_zero;

  int n_chk;
  int n_err;

  hilo_muldiv_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_cur   (hilo_cur),
    .flush      (flush),
    .stall      (stall),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue an operation from IDLE, hold start through the stall (as the
  // pipeline would), then check the write in the completion cycle at T+lat.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] cur,
                        input int lat, input logic [63:0] exp);
    start = 1'b1; op = o; src_a = a; src_b = b; hilo_cur = cur;
    #1;
    chk({tag, ".stall_T"}, stall, 1'b1);
    for (int i = 1; i < lat; i++) begin
      cyc();
      chk({tag, ".stall_busy"}, stall, 1'b1);
      chk({tag, ".we_busy"}, hilo_we, 1'b0);
    end
    cyc();
    start = 1'b0;
    #1;
    chk({tag, ".stall_done"}, stall, 1'b0);
    chk({tag, ".we_done"}, hilo_we, 1'b1);
    chk({tag, ".dz_done"}, div_zero, 1'b0);
    chk({tag, ".wdata"}, hilo_wdata, exp);
    cyc();
    chk({tag, ".we_after"}, hilo_we, 1'b0);
  endtask

  initial begin
    int we_seen;
    n_chk = 0; n_err = 0;
    rst = 1'b0; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    hilo_cur = '0; flush = 1'b0;

    // Reset state
    #12;
    chk("rst.stall", stall, 1'b0);
    chk("rst.we", hilo_we, 1'b0);
    chk("rst.dz", div_zero, 1'b0);
    chk("rst.wdata", hilo_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // MULT -2 * 3, MULTU 0xFFFFFFFF * 2
    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 64'd0, 2, 64'h0000_0001_FFFF_FFFE);
    run_op("mult_nn", 3'd0, 32'h8000_0000, 32'h8000_0000, 64'd0, 2, 64'h4000_0000_0000_0000);

    // Divides: HI=remainder, LO=quotient
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 64'd0, 33, 64'h0000_0001_FFFF_FFFD);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 64'd0, 33, 64'h0000_0002_0000_000E);
    run_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h10, 64'd0, 33, 64'h0000_000F_0FFF_FFFF);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 33, 64'h0000_0000_8000_0000);

    // Moves
    run_op("mtlo", 3'd5, 32'h1234_5678, 32'd0, 64'hAAAA_AAAA_BBBB_BBBB, 1, 64'hAAAA_AAAA_1234_5678);
    run_op("mthi", 3'd4, 32'hCAFE_F00D, 32'd0, 64'h1111_2222_3333_4444, 1, 64'hCAFE_F00D_3333_4444);

    // DIVU by zero: DONE at T+1, no write, one-cycle div_zero
    start = 1'b1; op = 3'd3; src_a = 32'd55; src_b = 32'd0;
    #1;
    chk("dz.stall_T", stall, 1'b1);
    cyc();
    start = 1'b0;
    #1;
    chk("dz.we", hilo_we, 1'b0);
    chk("dz.pulse", div_zero, 1'b1);
    chk("dz.stall_done", stall, 1'b0);
    cyc();
    chk("dz.pulse_end", div_zero, 1'b0);

    // Reserved opcode is never accepted
    start = 1'b1; op = 3'd6; src_a = 32'd1; src_b = 32'd1;
    #1;
    chk("rsv.stall", stall, 1'b0);
    cyc();
    start = 1'b0;
    #1;
    chk("rsv.we", hilo_we, 1'b0);
    chk("rsv.dz", div_zero, 1'b0);
    chk("rsv.stall_next", stall, 1'b0);

    // DIV flushed at iteration 10, then a MULT issued right away
    start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
    #1;
    chk("fl.stall_T", stall, 1'b1);
    for (int i = 1; i <= 10; i++) cyc();
    flush = 1'b1;
    #1;
    chk("fl.we_flush", hilo_we, 1'b0);
    cyc();
    flush = 1'b0;
    start = 1'b0;
    #1;
    chk("fl.idle_stall", stall, 1'b0);
    chk("fl.idle_we", hilo_we, 1'b0);
    run_op("fl.mult", 3'd0, 32'd5, 32'd6, 64'd0, 2, 64'd30);

    // Flush in DONE suppresses the write
    start = 1'b1; op = 3'd4; src_a = 32'h5555_5555; hilo_cur = 64'd0;
    #1;
    cyc();
    start = 1'b0; flush = 1'b1;
    #1;
    chk("fldone.we", hilo_we, 1'b0);
    chk("fldone.dz", div_zero, 1'b0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fldone.we_next", hilo_we, 1'b0);

    // Reset asserted mid-DIV aborts it with no write
    start = 1'b1; op = 3'd3; src_a = 32'd77; src_b = 32'd5;
    #1;
    for (int i = 0; i < 5; i++) cyc();
    start = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rstdiv.stall", stall, 1'b0);
    chk("rstdiv.wdata", hilo_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (hilo_we || stall) we_seen++;
    end
    chk("rstdiv.no_activity", 64'(we_seen), 64'd0);

    // Normal operation after reset recovery
    run_op("post.multu", 3'd1, 32'd7, 32'd9, 64'd0, 2, 64'd63);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
